// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial feeder for a single-bit sequence detector input.
//   Words are accepted through a valid/ready handshake and sent one bit per
//   clock on SER_OUT. Back-to-back words stream with no idle bit between them.
//
// Ports
//   CLOCK       in   rising-edge clock
//   RESET       in   synchronous, active-low reset
//   DATA        in   WIDTH-bit word, sampled on accept
//   LOAD_VALID  in   DATA is valid
//   LOAD_READY  out  a word can be accepted this cycle (combinational)
//   STALL       in   freeze serialization, hold the current bit
//   SER_OUT     out  serial bit (IDLE_BIT when no bit is being sent)
//   SER_VALID   out  SER_OUT carries a data bit
//   LAST        out  SER_OUT is the final bit of the current word
//   WORD_COUNT  out  number of words fully sent, wraps at 16 bits
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic             STALL,
  output logic             SER_OUT,
  output logic             SER_VALID,
  output logic             LAST,
  output logic [15:0]      WORD_COUNT
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]       sreg_q, sreg_d;
  logic                   ser_out_q, ser_out_d;
  logic                   ser_valid_q, ser_valid_d;
  logic                   last_q, last_d;
  logic [15:0]            word_count_q, word_count_d;

  logic                   at_last;
  logic                   accept;
  logic                   word_done;
  logic [WIDTH-1:0]       sreg_next;

  // Bit currently presented by a word held in the shift register.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) return w[0];
    else           return w[WIDTH-1];
  endfunction

  // Move the next bit into the presented position.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) return w >> 1;
    else           return w << 1;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sreg_d       = sreg_q;
    ser_out_d    = ser_out_q;
    ser_valid_d  = ser_valid_q;
    last_d       = last_q;
    word_count_d = word_count_q;

    at_last    = (state_q == ST_SHIFT) && (idx_q == LAST_IDX);
    LOAD_READY = RESET && !STALL && ((state_q == ST_IDLE) || at_last);
    accept     = LOAD_VALID && LOAD_READY;
    word_done  = at_last && !STALL;
    sreg_next  = shift_word(sreg_q);

    // The count advances on the edge that ends the last bit, whether or not
    // a following word is accepted on that same edge.
    if (word_done) begin
      word_count_d = word_count_q + 16'd1;
    end

    if (accept) begin
      // The output flop is loaded with the new word's first bit so it shows
      // up in the cycle right after the accept edge, gapless when streaming.
      state_d     = ST_SHIFT;
      idx_d       = '0;
      sreg_d      = DATA;
      ser_out_d   = head_bit(DATA);
      ser_valid_d = 1'b1;
      last_d      = (LAST_IDX == '0);
    end else if (word_done) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      sreg_d      = '0;
      ser_out_d   = IDLE_BIT;
      ser_valid_d = 1'b0;
      last_d      = 1'b0;
    end else if ((state_q == ST_SHIFT) && !STALL) begin
      idx_d       = idx_q + IDX_W'(1);
      sreg_d      = sreg_next;
      ser_out_d   = head_bit(sreg_next);
      ser_valid_d = 1'b1;
      last_d      = ((idx_q + IDX_W'(1)) == LAST_IDX);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      sreg_q       <= '0;
      ser_out_q    <= IDLE_BIT;
      ser_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sreg_q       <= sreg_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      last_q       <= last_d;
      word_count_q <= word_count_d;
    end
  end

  assign SER_OUT    = ser_out_q;
  assign SER_VALID  = ser_valid_q;
  assign LAST       = last_q;
  assign WORD_COUNT = word_count_q;

endmodule
